// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel debouncer for button and sensor inputs.
// Each channel has a 2-FF synchroniser and a 4-state confirm FSM. The FSM
// produces a clean level plus one-cycle press and release pulses.
// Optional long-press detection is enabled by defining the macro
// MULTI_DEBOUNCER_LONGPRESS_EN. When the macro is undefined, long_pulse is
// tied low and the counter is only wide enough for STABLE_CYCLES.
module multi_debouncer #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 8_000_000,
  parameter int HOLD_CYCLES   = 40_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic            any_press
);

`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
  // The counter is shared by stable confirmation and hold timing, so it is
  // sized for the larger of the two.
  localparam int CNT_MAX = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
`else
  localparam int CNT_MAX = STABLE_CYCLES;
`endif
  // The extra bit lets the hold counter park one past HOLD_CYCLES-1.
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_DONE   = CNT_W'(HOLD_CYCLES);
`endif

  // Reject nonsensical configurations at elaboration time.
  if ((N_CH < 1) || (STABLE_CYCLES < 1) || (HOLD_CYCLES < 1)) begin : g_bad_params
    $error("multi_debouncer: N_CH, STABLE_CYCLES and HOLD_CYCLES must all be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CONF_PRESS = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_CONF_REL   = 2'd3
  } state_t;

  logic [N_CH-1:0] sync1_reg;
  logic [N_CH-1:0] sync2_reg;
  logic [N_CH-1:0] press_next_vec;
  logic            any_press_reg;

  // Two-flop synchroniser; the channel FSMs only ever look at sync2_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= button;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             level_reg;
      logic             level_next;
      logic             press_reg;
      logic             press_next;
      logic             release_reg;
      logic             release_next;
      logic             b_s;
`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
      logic             long_reg;
      logic             long_next;
`endif

      assign b_s = sync2_reg[gi];

      // Channel state, counter and registered outputs.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg   <= ST_IDLE;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
          long_reg    <= 1'b0;
`endif
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          level_reg   <= level_next;
          press_reg   <= press_next;
          release_reg <= release_next;
`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
          long_reg    <= long_next;
`endif
        end
      end

      // Confirm FSM: a change is accepted only after STABLE_CYCLES equal samples.
      always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
        long_next    = 1'b0;
`endif
        case (state_reg)
          ST_IDLE: begin
            if (b_s) begin
              state_next = ST_CONF_PRESS;
              cnt_next   = '0;
            end
          end
          ST_CONF_PRESS: begin
            if (!b_s) begin
              // Bounce: back to idle without any pulse.
              state_next = ST_IDLE;
            end else if (cnt_reg == STABLE_LAST) begin
              state_next = ST_PRESSED;
              level_next = 1'b1;
              press_next = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          ST_PRESSED: begin
            if (!b_s) begin
              state_next = ST_CONF_REL;
              cnt_next   = '0;
            end
`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
            else if (cnt_reg != HOLD_DONE) begin
              // The counter stops at HOLD_DONE, so the long pulse fires once per press.
              cnt_next  = cnt_reg + CNT_ONE;
              long_next = (cnt_reg == HOLD_LAST);
            end
`endif
          end
          ST_CONF_REL: begin
            if (b_s) begin
              // Release was a bounce: return to pressed and restart hold timing.
              state_next = ST_PRESSED;
              cnt_next   = '0;
            end else if (cnt_reg == STABLE_LAST) begin
              state_next   = ST_IDLE;
              level_next   = 1'b0;
              release_next = 1'b1;
              cnt_next     = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end

      assign level[gi]          = level_reg;
      assign press_pulse[gi]    = press_reg;
      assign release_pulse[gi]  = release_reg;
      assign press_next_vec[gi] = press_next;
`ifdef MULTI_DEBOUNCER_LONGPRESS_EN
      assign long_pulse[gi]     = long_reg;
`endif
    end
  endgenerate

`ifndef MULTI_DEBOUNCER_LONGPRESS_EN
  assign long_pulse = '0;
`endif

  // Registered from the same next-state terms, so it lines up with press_pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_press_reg <= 1'b0;
    end else begin
      any_press_reg <= |press_next_vec;
    end
  end

  assign any_press = any_press_reg;

endmodule
